axi_master_bridge: RTL and testbench
====================================

// Module: axi_master_bridge
// PURPOSE
//  AXI3 master bridge between the core's IFU/LSU request ports and the system bus.
//  Successor to the single-outstanding bus interface, with per-source outstanding counters,
//  rid/bid-based response routing, fetch-cancel drop accounting, read/write ordering,
//  registered AR/AW/W slots and response-error reporting. Sits between the core and the AXI crossbar.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width; the byte-strobe width is DATA_W/8
//  ID_W        4   AXI id width
//  MAX_OUTST   4   max outstanding transactions per source (IFU rd, LSU rd, LSU wr)
//  IFU_ID      0   arid used for fetches
//  LSU_ID      1   arid/awid/wid used for LSU accesses
//  IFU_BEATS   4   beats per fetch burst (used only with the burst macro)
// PORTS
//  aclk         in   1         clock
//  aresetn      in   1         async active-low reset
//  inst_req     in   1         fetch request; inst_addr in ADDR_W
//  inst_addr_ok out  1         fetch accepted this cycle
//  inst_cancel  in   1         discard the data of every fetch outstanding now
//  inst_valid   out  1         fetch beat valid; inst_rdata out DATA_W; inst_error out 1
//  data_req     in   1         LSU request; data_wr in 1; data_addr in ADDR_W
//  data_wdata   in   DATA_W    store data; data_wstrb in DATA_W/8
//  data_addr_ok out  1         LSU request accepted this cycle
//  data_data_ok out  1         LSU load data or store completion; data_rdata out DATA_W; data_error out 1
//  ar*          out  -         arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid; arready in
//  r*           in   -         rid/rdata/rresp/rlast/rvalid; rready out
//  aw*          out  -         awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid; awready in
//  w*           out  -         wid/wdata/wstrb/wlast/wvalid; wready in
//  b*           in   -         bid/bresp/bvalid; bready out
// BEHAVIOUR
//  Reset (async): all *valid, *_ok, inst_error, data_error = 0; all counters = 0; arlen/arsize constant.
//  AR slot: free when !arvalid or arvalid&arready this cycle.
//  Read grant: LSU read beats IFU. LSU read requires slot free, lsu_rd_cnt<MAX_OUTST, wr_cnt==0 and AW/W slots empty.
//  IFU grant additionally requires ifu_cnt<MAX_OUTST and !inst_cancel.
//  *_addr_ok is combinational, same cycle as the request. Loser/stalled requester holds its request.
//  Accepted read loads araddr/arid; arvalid=1 the next cycle, payload stable until arready.
//  Counters increment on accept. Inc and dec in the same cycle leave the count unchanged.
//  arsize=log2(DATA_W/8); arburst=INCR(2'b01); lock/cache/prot=0; rready=bready=1 always.
//  R beat with rid==IFU_ID:
//   - rlast decrements ifu_cnt.
//   - If drop_cnt>0, the beat is discarded; drop_cnt decrements on rlast.
//   - Otherwise inst_valid=1 that cycle, inst_rdata=rdata, inst_error=(rresp!=OKAY).
//  R with rid==LSU_ID: data_data_ok=1, data_rdata=rdata, data_error=(rresp!=OKAY); lsu_rd_cnt--.
//  R or B with any other id: ignored, no counter change.
//  inst_cancel: drop_cnt<=ifu_cnt (after this cycle's inc/dec).
//   - An IFU beat arriving in the same cycle is dropped.
//   - Data of fetches accepted after the cancel returns normally.
//  Write accept requires AW and W slots empty, wr_cnt<MAX_OUTST and lsu_rd_cnt==0.
//   - awvalid and wvalid rise together the next cycle; each drops independently on its own ready.
//   - Slot stays busy until both have handshaken.
//   - awlen=0, wlast=1, wstrb=data_wstrb.
//  B with bid==LSU_ID: data_data_ok=1, data_error=(bresp!=OKAY), wr_cnt--.
//  LSU reads and writes are never outstanding together, so R(LSU) and B never collide on data_data_ok.
// CONFIGURATION
//  AXI_BRIDGE_IFU_BURST_EN defined:
//   - Fetch uses araddr=inst_addr aligned to IFU_BEATS*DATA_W/8 and arlen=IFU_BEATS-1.
//   - Adds port inst_beat (out, clog2(IFU_BEATS)), the beat index of inst_rdata.
//   - One inst_valid per beat; ifu_cnt counts bursts.
//  Undefined: fetch arlen=0 with unaligned araddr=inst_addr; inst_beat is absent.
// STRUCTURE
//  Package axi_bridge_pkg: RESP_OKAY/EXOKAY/SLVERR/DECERR, BURST_FIXED/INCR/WRAP, default IFU_ID/LSU_ID.
//  Sub-module axi_req_slot: one-entry valid+payload register, load/ready handshake, free flag.
//  axi_req_slot is instantiated for AR, AW and W.
// TESTING
//  1. Reset mid-burst (aresetn low with arvalid=1) -> next cycle arvalid=0 and all counters 0.
//  2. inst_req+data_req(rd) same cycle -> data_addr_ok=1, inst_addr_ok=0, next-cycle arid=1.
//     IFU accepted one cycle later.
//  3. 4 fetches with arready=1 and no R -> 5th has inst_addr_ok=0.
//     One R rid=0 returns -> next fetch accepted.
//  4. 2 fetches outstanding, inst_cancel, then 2 R rid=0 -> no inst_valid.
//     Third fetch's R -> inst_valid=1.
//  5. Store with awready=1 and wready held 0 for 3 cycles -> awvalid for 1 cycle, wvalid for 4.
//     Following load blocked until B; bresp=SLVERR -> data_error=1 with data_data_ok.
//  6. Burst macro on, inst_addr=0x1004 -> araddr=0x1000, arlen=3.
//     4 R beats give inst_beat 0..3, ifu_cnt-- on rlast only.

Source files
------------

// File: rtl/axi_bridge_pkg.sv
// Shared AXI3 constants and helpers for the core-to-bus master bridge.
package axi_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam int DEF_IFU_ID = 0;
  localparam int DEF_LSU_ID = 1;

  // AXI size encoding for a full-width beat of dataW bits.
  function automatic logic [2:0] axiSize(input int dataW);
    return 3'($clog2(dataW / 8));
  endfunction

endpackage

// File: rtl/axi_req_slot.sv
// One-entry request register: holds a payload with valid until the bus side handshakes.
module axi_req_slot
  import axi_bridge_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         free_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // A load may overwrite the entry in the same cycle it handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/axi_master_bridge.sv
// AXI3 master bridge for the IFU/LSU request ports; define AXI_BRIDGE_IFU_BURST_EN
// for multi-beat aligned fetch bursts with a beat index on inst_beat.
module axi_master_bridge
  import axi_bridge_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MAX_OUTST = 4,
  parameter int IFU_ID    = DEF_IFU_ID,
  parameter int LSU_ID    = DEF_LSU_ID,
  parameter int IFU_BEATS = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  input  logic                inst_cancel,
  output logic                inst_valid,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_error,
`ifdef AXI_BRIDGE_IFU_BURST_EN
  output logic [$clog2(IFU_BEATS)-1:0] inst_beat,
`endif
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_error,
  output logic [ID_W-1:0]     arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [3:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [ID_W-1:0]     wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_OUTST + 1);
  localparam int AR_W   = ID_W + ADDR_W + 4;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);
  localparam logic [ID_W-1:0]  IFU_ARID = ID_W'(IFU_ID);
  localparam logic [ID_W-1:0]  LSU_XID  = ID_W'(LSU_ID);

  logic [CNT_W-1:0]  ifuCnt_q, ifuCnt_d, lsuRdCnt_q, lsuRdCnt_d;
  logic [CNT_W-1:0]  wrCnt_q, wrCnt_d, dropCnt_q, dropCnt_d;
  logic              arFree, wrSlotsEmpty, lsuRdGo, ifuGo, wrGo;
  logic              ifuBeat, ifuDone, lsuRBeat, lsuBResp;
  logic [ADDR_W-1:0] fetchAddr;
  logic [3:0]        fetchLen;
  logic [AR_W-1:0]   arIn, arOut;
  logic              awFree, wFree;

  // Fetch address/length shaping depends on whether fetches are bursts.
`ifdef AXI_BRIDGE_IFU_BURST_EN
  localparam logic [ADDR_W-1:0] FETCH_MASK = ~(ADDR_W'(IFU_BEATS * STRB_W) - ADDR_W'(1));
  logic [$clog2(IFU_BEATS)-1:0] beat_q, beat_d;

  assign fetchAddr = inst_addr & FETCH_MASK;
  assign fetchLen  = 4'(IFU_BEATS - 1);
  assign beat_d    = rlast ? '0 : beat_q + 1'b1;
  assign inst_beat = beat_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)     beat_q <= '0;
    else if (ifuBeat) beat_q <= beat_d;
  end
`else
  assign fetchAddr = inst_addr;
  assign fetchLen  = 4'd0;
`endif

  assign wrSlotsEmpty = !awvalid && !wvalid;
  assign lsuRdGo = data_req && !data_wr && arFree && (lsuRdCnt_q < MAX_CNT)
                   && (wrCnt_q == '0) && wrSlotsEmpty;
  assign ifuGo   = inst_req && !lsuRdGo && arFree && (ifuCnt_q < MAX_CNT) && !inst_cancel;
  assign wrGo    = data_req && data_wr && wrSlotsEmpty && (wrCnt_q < MAX_CNT)
                   && (lsuRdCnt_q == '0);

  assign inst_addr_ok = ifuGo;
  assign data_addr_ok = lsuRdGo || wrGo;

  assign ifuBeat  = rvalid && (rid == IFU_ARID);
  assign ifuDone  = ifuBeat && rlast;
  assign lsuRBeat = rvalid && (rid == LSU_XID);
  assign lsuBResp = bvalid && (bid == LSU_XID);

  // A cancel in the same cycle as a fetch beat also discards that beat.
  assign inst_valid   = ifuBeat && (dropCnt_q == '0) && !inst_cancel;
  assign inst_rdata   = rdata;
  assign inst_error   = inst_valid && (rresp != RESP_OKAY);
  assign data_data_ok = lsuRBeat || lsuBResp;
  assign data_rdata   = rdata;
  assign data_error   = lsuRBeat ? (rresp != RESP_OKAY) : (lsuBResp && (bresp != RESP_OKAY));

  always_comb begin
    ifuCnt_d   = ifuCnt_q + CNT_W'(ifuGo) - CNT_W'(ifuDone);
    lsuRdCnt_d = lsuRdCnt_q + CNT_W'(lsuRdGo) - CNT_W'(lsuRBeat);
    wrCnt_d    = wrCnt_q + CNT_W'(wrGo) - CNT_W'(lsuBResp);
    dropCnt_d  = dropCnt_q;
    if (inst_cancel)                         dropCnt_d = ifuCnt_d;
    else if (ifuDone && dropCnt_q != '0)     dropCnt_d = dropCnt_q - 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ifuCnt_q   <= '0;
      lsuRdCnt_q <= '0;
      wrCnt_q    <= '0;
      dropCnt_q  <= '0;
    end else begin
      ifuCnt_q   <= ifuCnt_d;
      lsuRdCnt_q <= lsuRdCnt_d;
      wrCnt_q    <= wrCnt_d;
      dropCnt_q  <= dropCnt_d;
    end
  end

  assign arIn = lsuRdGo ? {LSU_XID, data_addr, 4'd0} : {IFU_ARID, fetchAddr, fetchLen};

  axi_req_slot #(.W(AR_W)) arSlot (
    .clk(aclk), .rst_n(aresetn), .load_i(lsuRdGo || ifuGo), .data_i(arIn),
    .ready_i(arready), .valid_o(arvalid), .data_o(arOut), .free_o(arFree)
  );

  axi_req_slot #(.W(ADDR_W)) awSlot (
    .clk(aclk), .rst_n(aresetn), .load_i(wrGo), .data_i(data_addr),
    .ready_i(awready), .valid_o(awvalid), .data_o(awaddr), .free_o(awFree)
  );

  axi_req_slot #(.W(DATA_W + STRB_W)) wSlot (
    .clk(aclk), .rst_n(aresetn), .load_i(wrGo), .data_i({data_wdata, data_wstrb}),
    .ready_i(wready), .valid_o(wvalid), .data_o({wdata, wstrb}), .free_o(wFree)
  );

  assign {arid, araddr, arlen} = arOut;
  assign arsize  = axiSize(DATA_W);
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign rready  = 1'b1;

  assign awid    = LSU_XID;
  assign awlen   = 4'd0;
  assign awsize  = axiSize(DATA_W);
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign wid     = LSU_XID;
  assign wlast   = 1'b1;
  assign bready  = 1'b1;

  // Slot free flags for AW/W are not used: writes wait for both slots to be fully empty.
  logic unusedFree;
  assign unusedFree = awFree ^ wFree;

endmodule

// File: tb/tb_axi_master_bridge.sv
// Directed bench for axi_master_bridge; AXI_BRIDGE_IFU_BURST_EN adds the fetch-burst case.
module tb_axi_master_bridge;
  import axi_bridge_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        inst_req, inst_cancel, inst_addr_ok, inst_valid, inst_error;
  logic [31:0] inst_addr, inst_rdata;
`ifdef AXI_BRIDGE_IFU_BURST_EN
  logic [1:0]  inst_beat;
`endif
  logic        data_req, data_wr, data_addr_ok, data_data_ok, data_error;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, rid, bid, wstrb;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int errorCount = 0;
  int checkCount = 0;

  always #5 aclk = ~aclk;

  axi_master_bridge dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_cancel(inst_cancel), .inst_valid(inst_valid), .inst_rdata(inst_rdata),
    .inst_error(inst_error),
`ifdef AXI_BRIDGE_IFU_BURST_EN
    .inst_beat(inst_beat),
`endif
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .data_error(data_error),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                               input logic dReq, input logic dWr, input logic [31:0] dAddr);
    inst_req  = iReq;
    inst_addr = iAddr;
    data_req  = dReq;
    data_wr   = dWr;
    data_addr = dAddr;
  endtask

  task automatic sendR(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp,
                       input logic last);
    rvalid = 1'b1;
    rid    = id;
    rdata  = d;
    rresp  = resp;
    rlast  = last;
  endtask

  initial begin
    aresetn = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    inst_cancel = 1'b0; data_wdata = '0; data_wstrb = '0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
    bvalid = 1'b0; bid = '0; bresp = '0;
    repeat (3) nextCycle();
    checkOutput("rst_arvalid", arvalid, 0);
    checkOutput("rst_awvalid", awvalid, 0);
    checkOutput("rst_wvalid", wvalid, 0);
    checkOutput("rst_ready", {rready, bready}, 2'b11);
    checkOutput("rst_arsize", arsize, 3'd2);

    // Reset while a read sits in the AR slot
    aresetn = 1'b1;
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h200);
    #1 checkOutput("t1_ld_ok", data_addr_ok, 1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 checkOutput("t1_arvalid_held", arvalid, 1);
    checkOutput("t1_araddr", araddr, 32'h200);
    aresetn = 1'b0;
    nextCycle();
    checkOutput("t1_arvalid_rst", arvalid, 0);
    aresetn = 1'b1;
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h40);
    #1 checkOutput("t1_wr_ok_cnt0", data_addr_ok, 1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    arready = 1'b1;
    nextCycle();

    // LSU read wins over a same-cycle fetch
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h300);
    #1 checkOutput("t2_data_ok", data_addr_ok, 1);
    checkOutput("t2_inst_ok", inst_addr_ok, 0);
    nextCycle();
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    #1 checkOutput("t2_arid_lsu", {arvalid, arid}, {1'b1, 4'd1});
    checkOutput("t2_araddr_lsu", araddr, 32'h300);
    checkOutput("t2_arlen", arlen, 0);
    checkOutput("t2_arburst", arburst, 2'b01);
    checkOutput("t2_inst_ok_late", inst_addr_ok, 1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 checkOutput("t2_arid_ifu", {arvalid, arid}, {1'b1, 4'd0});
    checkOutput("t2_araddr_ifu", araddr, 32'h100);
    nextCycle();
    checkOutput("t2_ar_idle", arvalid, 0);
    sendR(4'd1, 32'hDEAD0001, RESP_OKAY, 1'b1);
    #1 checkOutput("t2_lsu_r", {data_data_ok, data_error, inst_valid}, 3'b100);
    checkOutput("t2_lsu_rdata", data_rdata, 32'hDEAD0001);
    nextCycle();
    sendR(4'd0, 32'hCAFE0000, RESP_SLVERR, 1'b1);
    #1 checkOutput("t2_ifu_r", {inst_valid, inst_error, data_data_ok}, 3'b110);
    checkOutput("t2_ifu_rdata", inst_rdata, 32'hCAFE0000);
    nextCycle();
    sendR(4'd5, 32'h5555, RESP_OKAY, 1'b1);
    #1 checkOutput("t2_other_id", {inst_valid, data_data_ok}, 2'b00);
    nextCycle();
    rvalid = 1'b0;

    // Outstanding fetch limit
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h2000 + 32'(i * 4), 1'b0, 1'b0, 32'h0);
      #1 checkOutput($sformatf("t3_fetch%0d_ok", i), inst_addr_ok, 1);
      nextCycle();
    end
    sendR(4'd0, 32'h1111, RESP_OKAY, 1'b1);
    #1 checkOutput("t3_fifth_blocked", inst_addr_ok, 0);
    checkOutput("t3_ret_valid", inst_valid, 1);
    nextCycle();
    rvalid = 1'b0;
    #1 checkOutput("t3_fifth_ok", inst_addr_ok, 1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      sendR(4'd0, 32'hA000 + 32'(i), RESP_OKAY, 1'b1);
      #1 checkOutput($sformatf("t3_drain%0d", i), {inst_valid, inst_rdata}, {1'b1, 32'hA000 + 32'(i)});
      nextCycle();
    end
    rvalid = 1'b0;

    // Fetch cancel drops older data only
    applyStimulus(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    nextCycle();
    nextCycle();
    inst_cancel = 1'b1;
    #1 checkOutput("t4_cancel_blocks", inst_addr_ok, 0);
    nextCycle();
    inst_cancel = 1'b0;
    #1 checkOutput("t4_third_ok", inst_addr_ok, 1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      sendR(4'd0, 32'hBAD0 + 32'(i), RESP_OKAY, 1'b1);
      #1 checkOutput($sformatf("t4_drop%0d", i), inst_valid, 0);
      nextCycle();
    end
    sendR(4'd0, 32'h33330003, RESP_OKAY, 1'b1);
    #1 checkOutput("t4_third_r", {inst_valid, inst_rdata}, {1'b1, 32'h33330003});
    nextCycle();
    rvalid = 1'b0;
    applyStimulus(1'b1, 32'h3100, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    inst_cancel = 1'b1;
    sendR(4'd0, 32'hBAD9, RESP_OKAY, 1'b1);
    #1 checkOutput("t4_same_cycle_drop", inst_valid, 0);
    nextCycle();
    inst_cancel = 1'b0;
    rvalid = 1'b0;
    applyStimulus(1'b1, 32'h3200, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    sendR(4'd0, 32'h44440004, RESP_OKAY, 1'b1);
    #1 checkOutput("t4_after_cancel", inst_valid, 1);
    nextCycle();
    rvalid = 1'b0;

    // Store with a slow W channel, then a load held until B
    awready = 1'b1;
    wready  = 1'b0;
    data_wdata = 32'h11223344;
    data_wstrb = 4'b0110;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h400);
    #1 checkOutput("t5_st_ok", data_addr_ok, 1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h500);
    #1 checkOutput("t5_aw_w_up", {awvalid, wvalid}, 2'b11);
    checkOutput("t5_awaddr", awaddr, 32'h400);
    checkOutput("t5_wpayload", {wdata, wstrb, wlast}, {32'h11223344, 4'b0110, 1'b1});
    checkOutput("t5_ids", {awid, wid, awlen}, {4'd1, 4'd1, 4'd0});
    checkOutput("t5_ld_blocked0", data_addr_ok, 0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      if (i == 2) wready = 1'b1;
      #1 checkOutput($sformatf("t5_w_only%0d", i), {awvalid, wvalid}, 2'b01);
    end
    nextCycle();
    wready = 1'b0;
    #1 checkOutput("t5_w_done", wvalid, 0);
    checkOutput("t5_ld_blocked1", data_addr_ok, 0);
    bvalid = 1'b1; bid = 4'd1; bresp = RESP_SLVERR;
    #1 checkOutput("t5_b", {data_data_ok, data_error}, 2'b11);
    nextCycle();
    bvalid = 1'b0;
    #1 checkOutput("t5_ld_ok", data_addr_ok, 1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 checkOutput("t5_ld_ar", {arvalid, arid, araddr}, {1'b1, 4'd1, 32'h500});
    nextCycle();
    sendR(4'd1, 32'h55667788, RESP_OKAY, 1'b1);
    #1 checkOutput("t5_ld_data", {data_data_ok, data_error, data_rdata}, {2'b10, 32'h55667788});
    nextCycle();
    rvalid = 1'b0;

`ifdef AXI_BRIDGE_IFU_BURST_EN
    applyStimulus(1'b1, 32'h1004, 1'b0, 1'b0, 32'h0);
    #1 checkOutput("t6_fetch_ok", inst_addr_ok, 1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 checkOutput("t6_araddr", araddr, 32'h1000);
    checkOutput("t6_arlen", arlen, 4'd3);
    nextCycle();
    for (int b = 0; b < 4; b++) begin
      sendR(4'd0, 32'hF000 + 32'(b), RESP_OKAY, b == 3);
      #1 checkOutput($sformatf("t6_beat%0d", b), {inst_valid, inst_beat}, {1'b1, 2'(b)});
      nextCycle();
      checkOutput($sformatf("t6_cnt%0d", b), dut.ifuCnt_q, (b == 3) ? 0 : 1);
    end
    rvalid = 1'b0;
`endif

    nextCycle();
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
